id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus operand-forwarding muxes for the 5-stage MIPS core.
//  Captures decoded operands and control from ID and drives ALU inputs (input1, input2, aluControl) in EX.
//  Forwards EX/MEM and MEM/WB results to those inputs, detects load-use hazards, and inserts bubbles on stall/flush.
// PARAMETERS
//  DATA_W  32  datapath width (ALU operand width)
//  REG_AW  5   register index width
// PORTS
//  clk             in   1       rising-edge clock (single clock domain)
//  rst_n           in   1       asynchronous active-low reset
//  id_valid        in   1       ID holds a real instruction
//  id_rs/id_rt     in   REG_AW  source register indices
//  id_dest         in   REG_AW  destination index, already selected rt/rd by ID
//  id_uses_rt      in   1       instruction reads rt (R-type, beq, sw)
//  id_rs_data      in   DATA_W  register file read data for rs
//  id_rt_data      in   DATA_W  register file read data for rt
//  id_imm          in   DATA_W  sign-extended immediate
//  id_alu_src      in   1       1: input2 = imm; 0: input2 = forwarded rt
//  id_alu_op       in   3       ALU code: ADD=0 SUB=1 AND=2 OR=3 LT=4 XOR=5
//  id_reg_write    in   1       control bit, registered into EX
//  id_mem_read     in   1       control bit, registered into EX
//  id_mem_write    in   1       control bit, registered into EX
//  flush           in   1       taken branch/jump: kill the instruction currently in ID
//  mem_reg_write   in   1       EX/MEM stage writes a register
//  mem_rd          in   REG_AW  EX/MEM destination
//  mem_result      in   DATA_W  EX/MEM ALU result
//  wb_reg_write    in   1       MEM/WB stage writes a register
//  wb_rd           in   REG_AW  MEM/WB destination
//  wb_data         in   DATA_W  MEM/WB write-back data
//  stall_out       out  1       hold PC and IF/ID (combinational)
//  ex_valid        out  1       EX holds a real instruction
//  ex_input1       out  DATA_W  ALU input1, forwarded rs
//  ex_input2       out  DATA_W  ALU input2, imm or forwarded rt
//  ex_alu_control  out  3       ALU operation code
//  ex_store_data   out  DATA_W  forwarded rt, used as sw data
//  ex_dest         out  REG_AW  destination register
//  ex_reg_write    out  1       registered control
//  ex_mem_read     out  1       registered control
//  ex_mem_write    out  1       registered control
// BEHAVIOUR
//  - Reset (async, rst_n=0): every register is 0, so ex_valid=0, all controls=0, ex_alu_control=ADD, data=0.
//  - Normal cycle: at posedge, capture all id_* fields. Latency is 1 cycle from ID to EX outputs.
//  - Load-use stall: stall_out = ex_valid & ex_mem_read & ex_dest!=0 & id_valid & ~flush
//      & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
//  - Bubble: on stall or flush, next EX holds valid=0, reg_write/mem_read/mem_write=0, alu_op=ADD, data=0.
//  - After a stall: ID is held upstream and re-captured the following cycle, so there is exactly one bubble per load-use.
//  - Forwarding (combinational, from the registered rs/rt and data), per operand:
//      1. MEM hit when mem_reg_write & mem_rd!=0 & mem_rd==idx; takes priority.
//      2. Otherwise WB hit when wb_reg_write & wb_rd!=0 & wb_rd==idx.
//      3. Otherwise the registered register-file data.
//  - Register 0 is never forwarded. Distance-3 RAW is resolved by the write-first register file, not here.
//  - ex_input2 uses the registered imm when alu_src=1; ex_store_data is always forwarded rt.
//  - Simultaneous flush and stall: flush wins; stall_out forced 0, bubble inserted.
//  - Reset mid-operation: contents are discarded immediately; the first cycle after release is a bubble.
// CONFIGURATION
//  EX_PERF_CNT_EN: defined adds output perf_stall_cnt[31:0] and perf_fwd_cnt[31:0].
//    perf_stall_cnt +1 per stall_out cycle; perf_fwd_cnt +1 per ex_valid cycle with any forward hit.
//    Both wrap at 2^32 and reset to 0.
//  EX_PERF_CNT_EN undefined: no counter ports and no counter logic.
// STRUCTURE
//  mips_pkg:
//    - alu_op_e (ADD..XOR codes)
//    - fwd_sel_e {FWD_RF, FWD_MEM, FWD_WB}
//    - id_ex_t struct (valid, rs, rt, dest, data, imm, controls)
//    - BUBBLE constant of type id_ex_t
//  Sub-module ex_forward_unit: pure combinational; given idx plus the MEM/WB write ports, returns fwd_sel_e.
//    Instantiated twice (rs, rt).
// TESTING
//  1. r3 in MEM: mem_rd=3, mem_reg_write=1, mem_result=5; EX reads rs=3 -> ex_input1=5.
//  2. r4 in both stages: mem_result=7 and wb_data=9 both target r4 -> ex_input1=7 (MEM priority).
//  3. Load-use: lw r2 in EX, ID add reads rt=2 -> stall_out=1 for 1 cycle, next ex_valid=0, then add issues with WB-forwarded value.
//  4. r0 writer: mem_rd=0, mem_reg_write=1, mem_result=32'hDEAD; rs=0 -> ex_input1=0.
//  5. Flush and stall together: flush=1 with load-use conditions -> stall_out=0, next ex_valid=0 and ex_reg_write=0.
//  6. Reset mid-stream: rst_n low asynchronously -> all outputs 0 before next edge; first post-reset cycle ex_valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the ID/EX operand stage: ALU codes, forwarding selects and the
// ID/EX pipeline register layout.
package mips_pkg;

    localparam int unsigned ID_EX_DATA_W = 32;
    localparam int unsigned ID_EX_REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_LT  = 3'd4,
        ALU_XOR = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                    valid;
        logic [ID_EX_REG_AW-1:0] rs;
        logic [ID_EX_REG_AW-1:0] rt;
        logic [ID_EX_REG_AW-1:0] dest;
        logic [ID_EX_DATA_W-1:0] rs_data;
        logic [ID_EX_DATA_W-1:0] rt_data;
        logic [ID_EX_DATA_W-1:0] imm;
        logic                    alu_src;
        alu_op_e                 alu_op;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
    } id_ex_t;

    // Bubble is all-zero apart from the explicit ADD so it reads as a harmless NOP.
    localparam id_ex_t BUBBLE = '{
        valid:     1'b0,
        rs:        '0,
        rt:        '0,
        dest:      '0,
        rs_data:   '0,
        rt_data:   '0,
        imm:       '0,
        alu_src:   1'b0,
        alu_op:    ALU_ADD,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0
    };

    function automatic logic [ID_EX_DATA_W-1:0] fwd_mux(
        input fwd_sel_e                sel,
        input logic [ID_EX_DATA_W-1:0] rf_data,
        input logic [ID_EX_DATA_W-1:0] mem_data,
        input logic [ID_EX_DATA_W-1:0] wb_data
    );
        logic [ID_EX_DATA_W-1:0] res;
        res = rf_data;
        unique case (sel)
            FWD_MEM: res = mem_data;
            FWD_WB:  res = wb_data;
            default: res = rf_data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID-side inputs, MEM/WB forwarding sources and EX-side outputs of the ID/EX operand stage.
interface id_ex_operand_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_uses_rt;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_alu_src;
    logic [2:0]        id_alu_op;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              flush;

    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic [DATA_W-1:0] mem_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              stall_out;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_input1;
    logic [DATA_W-1:0] ex_input2;
    logic [2:0]        ex_alu_control;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;

    modport master (
        output id_valid, id_rs, id_rt, id_dest, id_uses_rt, id_rs_data, id_rt_data, id_imm,
               id_alu_src, id_alu_op, id_reg_write, id_mem_read, id_mem_write, flush,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
        input  stall_out, ex_valid, ex_input1, ex_input2, ex_alu_control, ex_store_data,
               ex_dest, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dest, id_uses_rt, id_rs_data, id_rt_data, id_imm,
               id_alu_src, id_alu_op, id_reg_write, id_mem_read, id_mem_write, flush,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
        output stall_out, ex_valid, ex_input1, ex_input2, ex_alu_control, ex_store_data,
               ex_dest, ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/ex_forward_unit.sv
// Per-operand forwarding select: MEM beats WB, register 0 never forwards.
module ex_forward_unit
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output fwd_sel_e          sel
);
    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == idx);
    assign wb_hit  = wb_reg_write && (wb_rd != '0) && (wb_rd == idx);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
// Optional EX_PERF_CNT_EN adds stall and forward-hit performance counters.
module id_ex_operand_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_DATA_W,
    parameter int unsigned REG_AW = ID_EX_REG_AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_operand_stage_if.slave  bus
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_fwd_cnt
`endif
);
    id_ex_t   ex_q;
    id_ex_t   ex_d;
    logic     stall;
    logic     load_use;
    fwd_sel_e rs_sel;
    fwd_sel_e rt_sel;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // Only a load already in EX can hazard; everything else is covered by forwarding.
    assign load_use = (ex_q.dest == bus.id_rs) || (bus.id_uses_rt && (ex_q.dest == bus.id_rt));
    assign stall    = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && bus.id_valid &&
                      !bus.flush && load_use;
    assign bus.stall_out = stall;

    always_comb begin
        ex_d = BUBBLE;
        if (!(stall || bus.flush)) begin
            ex_d.valid     = bus.id_valid;
            ex_d.rs        = bus.id_rs;
            ex_d.rt        = bus.id_rt;
            ex_d.dest      = bus.id_dest;
            ex_d.rs_data   = bus.id_rs_data;
            ex_d.rt_data   = bus.id_rt_data;
            ex_d.imm       = bus.id_imm;
            ex_d.alu_src   = bus.id_alu_src;
            ex_d.alu_op    = alu_op_e'(bus.id_alu_op);
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
            ex_d.mem_write = bus.id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    ex_forward_unit #(.REG_AW(REG_AW)) u_fwd_rs (
        .idx           (ex_q.rs),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd        (bus.mem_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .sel           (rs_sel)
    );

    ex_forward_unit #(.REG_AW(REG_AW)) u_fwd_rt (
        .idx           (ex_q.rt),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd        (bus.mem_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .sel           (rt_sel)
    );

    assign rs_fwd = fwd_mux(rs_sel, ex_q.rs_data, bus.mem_result, bus.wb_data);
    assign rt_fwd = fwd_mux(rt_sel, ex_q.rt_data, bus.mem_result, bus.wb_data);

    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_input1      = rs_fwd;
    assign bus.ex_input2      = ex_q.alu_src ? ex_q.imm : rt_fwd;
    assign bus.ex_alu_control = ex_q.alu_op;
    assign bus.ex_store_data  = rt_fwd;
    assign bus.ex_dest        = ex_q.dest;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;

`ifdef EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic        fwd_hit;

    assign fwd_hit = ex_q.valid && ((rs_sel != FWD_RF) || (rt_sel != FWD_RF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (fwd_hit) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding priority, r0, load-use, flush, reset.
module tb_id_ex_operand_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef EX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
`endif

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef EX_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dest, input logic uses_rt,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic alu_src, input logic [2:0] op,
                          input logic rw, input logic mr, input logic mw);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_dest      = dest;
        bus.id_uses_rt   = uses_rt;
        bus.id_rs_data   = rsd;
        bus.id_rt_data   = rtd;
        bus.id_imm       = imm;
        bus.id_alu_src   = alu_src;
        bus.id_alu_op    = op;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
    endtask

    task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
        bus.mem_reg_write = mw;
        bus.mem_rd        = mrd;
        bus.mem_result    = mres;
        bus.wb_reg_write  = ww;
        bus.wb_rd         = wrd;
        bus.wb_data       = wdat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #3;
        check("reset_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("reset_aluctl", {29'b0, bus.ex_alu_control}, 32'd0);
        check("reset_input1", bus.ex_input1, 32'd0);
        check("reset_regwrite", {31'b0, bus.ex_reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MEM forwarding to rs
        set_id(1'b1, 5'd3, 5'd1, 5'd6, 1'b1, 32'd100, 32'd20, 32'h0, 1'b0, 3'd1,
               1'b1, 1'b0, 1'b0);
        step();
        check("t1_rf_input1", bus.ex_input1, 32'd100);
        set_fwd(1'b1, 5'd3, 32'd5, 1'b0, 5'd0, 32'h0);
        #1;
        check("t1_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("t1_mem_input1", bus.ex_input1, 32'd5);
        check("t1_input2_rf", bus.ex_input2, 32'd20);
        check("t1_aluctl", {29'b0, bus.ex_alu_control}, 32'd1);
        check("t1_dest", {27'b0, bus.ex_dest}, 32'd6);
        check("t1_regwrite", {31'b0, bus.ex_reg_write}, 32'd1);

        // MEM beats WB, imm selected for input2
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd4, 5'd4, 5'd8, 1'b1, 32'd1, 32'd2, 32'h10, 1'b1, 3'd3,
               1'b1, 1'b0, 1'b0);
        step();
        set_fwd(1'b1, 5'd4, 32'd7, 1'b1, 5'd4, 32'd9);
        #1;
        check("t2_mem_prio", bus.ex_input1, 32'd7);
        check("t2_imm_input2", bus.ex_input2, 32'h10);
        check("t2_store_fwd", bus.ex_store_data, 32'd7);
        bus.mem_reg_write = 1'b0;
        #1;
        check("t2_wb_input1", bus.ex_input1, 32'd9);
        bus.wb_reg_write = 1'b0;
        #1;
        check("t2_rf_input1", bus.ex_input1, 32'd1);
        check("t2_rf_store", bus.ex_store_data, 32'd2);

        // Register 0 never forwards
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0,
               1'b0, 1'b0, 1'b0);
        step();
        set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        #1;
        check("t4_r0_input1", bus.ex_input1, 32'd0);
        check("t4_r0_store", bus.ex_store_data, 32'd0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Load-use: lw r2 then add reading rt=2
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, 32'd0, 32'd0, 32'd8, 1'b1, 3'd0,
               1'b1, 1'b1, 1'b0);
        step();
        check("t3_lw_memread", {31'b0, bus.ex_mem_read}, 32'd1);
        set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 32'd10, 32'hBAD, 32'd0, 1'b0, 3'd0,
               1'b1, 1'b0, 1'b0);
        #1;
        check("t3_stall", {31'b0, bus.stall_out}, 32'd1);
        step();
        check("t3_bubble_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("t3_bubble_rw", {31'b0, bus.ex_reg_write}, 32'd0);
        check("t3_bubble_input1", bus.ex_input1, 32'd0);
        check("t3_stall_drop", {31'b0, bus.stall_out}, 32'd0);
        step();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h44);
        #1;
        check("t3_add_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("t3_add_input1", bus.ex_input1, 32'd10);
        check("t3_add_wb_input2", bus.ex_input2, 32'h44);
        check("t3_add_store", bus.ex_store_data, 32'h44);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // rt match without rt use does not stall; flush overrides stall
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, 32'd0, 32'd0, 32'd8, 1'b1, 3'd0,
               1'b1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b0, 32'd10, 32'd3, 32'd0, 1'b1, 3'd0,
               1'b1, 1'b0, 1'b0);
        #1;
        check("t5_no_rt_use", {31'b0, bus.stall_out}, 32'd0);
        bus.id_uses_rt = 1'b1;
        #1;
        check("t5_stall_pre", {31'b0, bus.stall_out}, 32'd1);
        bus.flush = 1'b1;
        #1;
        check("t5_flush_stall", {31'b0, bus.stall_out}, 32'd0);
        step();
        bus.flush = 1'b0;
        check("t5_flush_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("t5_flush_rw", {31'b0, bus.ex_reg_write}, 32'd0);

        // Asynchronous reset mid-stream
        set_id(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 32'h55, 32'h66, 32'h0, 1'b0, 3'd5,
               1'b1, 1'b0, 1'b1);
        step();
        check("t6_pre_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("t6_pre_aluctl", {29'b0, bus.ex_alu_control}, 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("t6_rst_input1", bus.ex_input1, 32'd0);
        check("t6_rst_memwrite", {31'b0, bus.ex_mem_write}, 32'd0);
        check("t6_rst_aluctl", {29'b0, bus.ex_alu_control}, 32'd0);
        check("t6_rst_dest", {27'b0, bus.ex_dest}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("t6_post_valid", {31'b0, bus.ex_valid}, 32'd0);
        step();
        check("t6_recapture", bus.ex_input1, 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
